// File: rtl/rom_fetch_pkg.sv
// Shared types, constants and helpers for the instruction fetch stage.
package rom_fetch_pkg;

  localparam int FETCH_FIFO_DEPTH     = 2;
  localparam int DEFAULT_BITS         = 16;
  localparam int DEFAULT_ADDRESS_BITS = 8;
  localparam int DEFAULT_RESET_VECTOR = 0;

  // Occupancy of the skid FIFO (0..2) and the "words owed" total (0..3).
  typedef logic [1:0] fifo_count_t;

  localparam fifo_count_t FIFO_FULL = 2'd2;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [DEFAULT_BITS-1:0]         word;
    logic [DEFAULT_ADDRESS_BITS-1:0] pc;
  } fetch_entry_t;

  // Words already held plus the one still in the ROM, minus the one leaving.
  // Never exceeds 3 and never underflows because pop implies count >= 1.
  function automatic fifo_count_t owed_words(input fifo_count_t count,
                                             input logic        inflight,
                                             input logic        pop);
    return count + {1'b0, inflight} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/rom_fetch_if.sv
// Fetch-stage bus: ROM address/data, branch redirect and the decode handshake.
interface rom_fetch_if
  import rom_fetch_pkg::*;
#(
  parameter int BITS         = DEFAULT_BITS,
  parameter int ADDRESS_BITS = DEFAULT_ADDRESS_BITS
);
  logic [ADDRESS_BITS-1:0] ROM_ADDRESS;
  logic [BITS-1:0]         ROM_DATA;
  logic                    BRANCH_VALID;
  logic [ADDRESS_BITS-1:0] BRANCH_TARGET;
  logic [BITS-1:0]         INSTR_OUT;
  logic [ADDRESS_BITS-1:0] INSTR_PC;
  logic                    INSTR_VALID;
  logic                    INSTR_READY;

  // Fetch stage side.
  modport master (
    output ROM_ADDRESS, INSTR_OUT, INSTR_PC, INSTR_VALID,
    input  ROM_DATA, BRANCH_VALID, BRANCH_TARGET, INSTR_READY
  );

  // ROM / branch unit / decode side.
  modport slave (
    input  ROM_ADDRESS, INSTR_OUT, INSTR_PC, INSTR_VALID,
    output ROM_DATA, BRANCH_VALID, BRANCH_TARGET, INSTR_READY
  );
endinterface

// File: rtl/rom_fetch_chk.sv
// Overflow guard for the fetch skid FIFO: a capture must never land on a full FIFO.
module fetch_fifo_chk
  import rom_fetch_pkg::*;
(
  input logic        i_clk,
  input logic        i_rst,
  input logic        i_push,
  input logic        i_flush,
  input fifo_count_t i_count
);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && !i_flush && (i_count == FIFO_FULL)));

endmodule

// File: rtl/rom_fetch_fifo.sv
// Two-entry skid FIFO with flush; slot 0 is the registered head.
module fetch_fifo
  import rom_fetch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_BITS + DEFAULT_ADDRESS_BITS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [WIDTH-1:0]  i_data,
  output logic [WIDTH-1:0]  o_head,
  output logic              o_valid,
  output fifo_count_t       o_count
);

  logic [WIDTH-1:0] r_slot0;
  logic [WIDTH-1:0] r_slot1;
  fifo_count_t      r_count;
  logic             r_valid;
  logic             w_pop;

  // A pop on an empty FIFO is meaningless, so it is dropped here.
  assign w_pop = i_pop & r_valid;

  // Slot/count update: flush wins, otherwise push and pop combine.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_count <= 2'd0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_count <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_slot0 <= i_data;
          end else begin
            r_slot1 <= i_data;
          end
          r_count <= r_count + 2'd1;
          r_valid <= 1'b1;
        end
        2'b01: begin
          r_slot0 <= r_slot1;
          r_count <= r_count - 2'd1;
          r_valid <= (r_count == 2'd2);
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_slot0 <= i_data;
          end else begin
            r_slot0 <= r_slot1;
            r_slot1 <= i_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_head  = r_slot0;
  assign o_valid = r_valid;
  assign o_count = r_count;

  fetch_fifo_chk u_chk (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_push),
    .i_flush (i_flush),
    .i_count (r_count)
  );

endmodule

// File: rtl/rom_fetch.sv
// Instruction fetch stage: PC, in-flight read tracking, issue control and
// ROM address mux in front of a 1-cycle synchronous program ROM.
module rom_fetch
  import rom_fetch_pkg::*;
#(
  parameter int BITS         = DEFAULT_BITS,
  parameter int ADDRESS_BITS = DEFAULT_ADDRESS_BITS,
  parameter int RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input logic         i_clk,
  input logic         i_rst,
  rom_fetch_if.master bus
);

  localparam logic [ADDRESS_BITS-1:0] RV = ADDRESS_BITS'(RESET_VECTOR);
  localparam int ENTRY_BITS = BITS + ADDRESS_BITS;

  logic [ADDRESS_BITS-1:0] r_pc;
  logic [ADDRESS_BITS-1:0] r_inflight_pc;
  logic                    r_inflight;

  logic [ADDRESS_BITS-1:0] w_rom_address;
  logic                    w_pop;
  logic                    w_issue;
  logic                    w_push;
  logic                    w_head_valid;
  fifo_count_t             w_count;
  logic [ENTRY_BITS-1:0]   w_head;
  logic [BITS-1:0]         w_head_word;
  logic [ADDRESS_BITS-1:0] w_head_pc;

  // A redirect is issued to the ROM in the same cycle it arrives.
  always_comb begin
    w_rom_address = r_pc;
    if (bus.BRANCH_VALID) begin
      w_rom_address = bus.BRANCH_TARGET;
    end else begin
      w_rom_address = r_pc;
    end
  end

  assign w_pop  = w_head_valid & bus.INSTR_READY;
  // Keep at most two words held or owed; a branch always issues its target.
  assign w_issue = bus.BRANCH_VALID |
                   (owed_words(w_count, r_inflight, w_pop) < FIFO_FULL);
  // Data returning for a read issued before a branch is stale.
  assign w_push = r_inflight & ~bus.BRANCH_VALID;

  // PC advance and in-flight bookkeeping for the word now being read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc          <= RV;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (w_issue) begin
      r_pc          <= w_rom_address + ADDRESS_BITS'(1);
      r_inflight    <= 1'b1;
      r_inflight_pc <= w_rom_address;
    end else begin
      r_inflight    <= 1'b0;
    end
  end

  fetch_fifo #(.WIDTH(ENTRY_BITS)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.BRANCH_VALID),
    .i_data  ({bus.ROM_DATA, r_inflight_pc}),
    .o_head  (w_head),
    .o_valid (w_head_valid),
    .o_count (w_count)
  );

  assign {w_head_word, w_head_pc} = w_head;

  assign bus.ROM_ADDRESS = w_rom_address;
  assign bus.INSTR_OUT   = w_head_word;
  assign bus.INSTR_PC    = w_head_pc;
  assign bus.INSTR_VALID = w_head_valid;

endmodule

// File: tb/tb_rom_fetch.sv
// Directed + randomized bench for rom_fetch with a ROM model and a
// delivered-PC scoreboard.
module tb_rom_fetch;
  import rom_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   n_accept;

  logic [15:0] mem [256];
  logic [7:0]  exp_pc;

  logic        smp_valid;
  logic [15:0] smp_out;
  logic [7:0]  smp_pc;
  logic [7:0]  smp_addr;
  logic [1:0]  smp_count;

  rom_fetch_if #(.BITS(16), .ADDRESS_BITS(8)) bus ();

  rom_fetch #(.BITS(16), .ADDRESS_BITS(8), .RESET_VECTOR(0)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'hA500 | 16'(k);
  end

  always @(posedge clk) bus.ROM_DATA <= mem[bus.ROM_ADDRESS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, score any accepted word.
  task automatic tick();
    fetch_entry_t exp_e;
    @(negedge clk);
    smp_valid = bus.INSTR_VALID;
    smp_out   = bus.INSTR_OUT;
    smp_pc    = bus.INSTR_PC;
    smp_addr  = bus.ROM_ADDRESS;
    smp_count = dut.u_fifo.o_count;
    if (bus.INSTR_VALID === 1'b1 && bus.INSTR_READY === 1'b1) begin
      exp_e.pc   = exp_pc;
      exp_e.word = 16'hA500 | {8'h00, exp_pc};
      check("deliver", 32'({smp_out, smp_pc}), 32'(exp_e));
      exp_pc = exp_pc + 8'd1;
      n_accept++;
    end
    if (bus.BRANCH_VALID === 1'b1) exp_pc = bus.BRANCH_TARGET;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] wrap_pc [4];
    int rand_accept_start;
    wrap_pc[0] = 8'hFE; wrap_pc[1] = 8'hFF; wrap_pc[2] = 8'h00; wrap_pc[3] = 8'h01;
    n_checks = 0;
    n_errors = 0;
    n_accept = 0;
    exp_pc   = 8'h00;
    rst = 1'b1;
    bus.INSTR_READY   = 1'b1;
    bus.BRANCH_VALID  = 1'b0;
    bus.BRANCH_TARGET = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    tick();
    check("rst_valid", 32'(smp_valid), 32'd0);
    check("rst_out",   32'(smp_out),   32'd0);
    check("rst_pc",    32'(smp_pc),    32'd0);
    check("rst_addr",  32'(smp_addr),  32'd0);

    // Release and stream
    rst = 1'b0;
    tick(); check("boot_c0_valid", 32'(smp_valid), 32'd0);
    tick(); check("boot_c1_valid", 32'(smp_valid), 32'd0);
    tick();
    check("boot_c2_valid", 32'(smp_valid), 32'd1);
    check("boot_c2_out",   32'(smp_out),   32'hA500);
    check("boot_c2_pc",    32'(smp_pc),    32'h00);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stream_nogap", 32'(smp_valid), 32'd1);
    end

    // Backpressure with PC 3 at the head
    bus.INSTR_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(smp_valid), 32'd1);
      check("bp_out",   32'(smp_out),   32'hA503);
      check("bp_pc",    32'(smp_pc),    32'h03);
      check("bp_addr",  32'(smp_addr),  32'h05);
    end
    check("bp_count", 32'(smp_count), 32'd2);
    bus.INSTR_READY = 1'b1;
    tick();
    check("bp_resume_pc", 32'(smp_pc), 32'h03);
    repeat (4) tick();

    // Branch while full
    bus.INSTR_READY = 1'b0;
    tick();
    tick();
    bus.BRANCH_VALID  = 1'b1;
    bus.BRANCH_TARGET = 8'h40;
    tick();
    check("br_full_count", 32'(smp_count), 32'd2);
    bus.BRANCH_VALID = 1'b0;
    bus.INSTR_READY  = 1'b1;
    tick();
    check("br_n1_valid", 32'(smp_valid), 32'd0);
    tick();
    check("br_n2_valid", 32'(smp_valid), 32'd1);
    check("br_n2_out",   32'(smp_out),   32'hA540);
    check("br_n2_pc",    32'(smp_pc),    32'h40);
    tick();
    check("br_n3_pc",    32'(smp_pc),    32'h41);

    // Back-to-back branches
    bus.BRANCH_VALID  = 1'b1;
    bus.BRANCH_TARGET = 8'h10;
    tick();
    bus.BRANCH_TARGET = 8'h20;
    tick();
    check("b2b_n1_valid", 32'(smp_valid), 32'd0);
    bus.BRANCH_VALID = 1'b0;
    tick();
    check("b2b_n2_valid", 32'(smp_valid), 32'd0);
    tick();
    check("b2b_first_pc",  32'(smp_pc),  32'h20);
    check("b2b_first_out", 32'(smp_out), 32'hA520);
    tick();
    check("b2b_second_pc", 32'(smp_pc),  32'h21);

    // Wrap around the top of the address space
    bus.BRANCH_VALID  = 1'b1;
    bus.BRANCH_TARGET = 8'hFE;
    tick();
    bus.BRANCH_VALID = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wrap_valid", 32'(smp_valid), 32'd1);
      check("wrap_pc",    32'(smp_pc),    32'(wrap_pc[i]));
      check("wrap_out",   32'(smp_out),   32'(16'hA500 | {8'h00, wrap_pc[i]}));
    end

    // Asynchronous reset pulse between edges
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.INSTR_VALID), 32'd0);
    check("arst_addr",  32'(bus.ROM_ADDRESS), 32'd0);
    check("arst_out",   32'(bus.INSTR_OUT),   32'd0);
    #1;
    rst = 1'b0;
    exp_pc = 8'h00;
    tick(); check("rboot_c0_valid", 32'(smp_valid), 32'd0);
    tick(); check("rboot_c1_valid", 32'(smp_valid), 32'd0);
    tick();
    check("rboot_c2_valid", 32'(smp_valid), 32'd1);
    check("rboot_c2_out",   32'(smp_out),   32'hA500);
    check("rboot_c2_pc",    32'(smp_pc),    32'h00);

    // Random READY and occasional branches against the scoreboard
    rand_accept_start = n_accept;
    for (int i = 0; i < 1000; i++) begin
      bus.INSTR_READY = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        bus.BRANCH_VALID  = 1'b1;
        bus.BRANCH_TARGET = 8'($urandom);
      end else begin
        bus.BRANCH_VALID  = 1'b0;
      end
      tick();
    end
    bus.BRANCH_VALID = 1'b0;
    bus.INSTR_READY  = 1'b1;
    repeat (4) tick();
    check("rand_progress", 32'((n_accept - rand_accept_start) > 150), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rom_fetch.md
Name: rom_fetch

Overview:
Instruction fetch stage that sits directly upstream of the synchronous program ROM (1-cycle registered read, no read enable).
- Owns the program counter and drives the ROM address every cycle.
- Tracks the single in-flight read and captures returning words into a 2-entry skid FIFO.
- Presents instructions to decode over a valid/ready handshake, with PC tag and single-cycle branch redirect/flush.

Parameters:
BITS, 16, instruction word width (matches ROM data width)
ADDRESS_BITS, 8, program address width; PC wraps modulo 2^ADDRESS_BITS
RESET_VECTOR, 0, first fetch address after reset

Ports:
CLK  in  1  system clock; all state on rising edge
RST  in  1  reset, asynchronous, active-high
ROM_ADDRESS  out  ADDRESS_BITS  address to ROM; ROM returns mem[ROM_ADDRESS] on ROM_DATA after next CLK edge
ROM_DATA  in  BITS  ROM registered read data
BRANCH_VALID  in  1  one-cycle redirect request
BRANCH_TARGET  in  ADDRESS_BITS  redirect address, sampled when BRANCH_VALID=1
INSTR_OUT  out  BITS  instruction word at FIFO head
INSTR_PC  out  ADDRESS_BITS  address INSTR_OUT was fetched from
INSTR_VALID  out  1  head entry valid
INSTR_READY  in  1  decode accepts head this cycle (pop = INSTR_VALID & INSTR_READY)

Behaviour:
- Reset (async assert, held while RST=1):
  - pc=RESET_VECTOR, inflight=0, FIFO count=0.
  - INSTR_VALID=0, INSTR_OUT=0, INSTR_PC=0.
  - ROM_ADDRESS=RESET_VECTOR.
  - Reset asserted mid-stream discards the FIFO and the in-flight read immediately.
- State:
  - pc: next address to issue.
  - inflight flag plus inflight_pc: address issued last cycle.
  - FIFO: 2 entries of {word, pc}, count 0..2.
- ROM_ADDRESS (combinational): BRANCH_VALID ? BRANCH_TARGET : pc. ROM always reads; data is ignored unless inflight=1.
- Issue condition (normal): issue = (count + inflight - pop) < 2, i.e. never more than 2 words owed/held.
  - On issue: pc <= ROM_ADDRESS + 1 (mod 2^ADDRESS_BITS); inflight <= 1; inflight_pc <= ROM_ADDRESS.
  - Else: pc and ROM_ADDRESS are held; inflight <= 0.
- Capture: if inflight=1 and no branch this cycle, push {ROM_DATA, inflight_pc} into FIFO.
  - Push and pop in the same cycle keep count unchanged.
  - Push when count=2 cannot occur (guaranteed by the issue rule); assert in simulation.
- Output:
  - INSTR_OUT/INSTR_PC/INSTR_VALID come from registered FIFO head.
  - While INSTR_VALID=1 and INSTR_READY=0, head values are stable.
- Latency and throughput:
  - Address issued in cycle n -> ROM_DATA valid cycle n+1 -> INSTR_VALID in cycle n+2.
  - Sustained 1 instr/cycle with INSTR_READY held high.
- Branch (BRANCH_VALID=1 in cycle n):
  - FIFO flushed (count<=0, INSTR_VALID<=0 at edge n).
  - In-flight read discarded; no capture in cycle n.
  - Unconditional issue of BRANCH_TARGET in cycle n: inflight_pc<=target, pc<=target+1.
  - Target word valid at cycle n+2.
  - A pop in the branch cycle is still a legal accept of the old head; the branch wins for all other state.
  - Back-to-back branches: each cycle's target overrides the previous one.
- Wrap: pc=2^ADDRESS_BITS-1 issues, then next pc=0; INSTR_PC reports 0 for the following word.
- Stall: ROM_ADDRESS stays at pc while issue=0; the ROM re-read is harmless.

Decomposition:
- Shared package:
  - FETCH_FIFO_DEPTH=2.
  - fetch entry struct {word[BITS], pc[ADDRESS_BITS]}.
  - RESET_VECTOR default constant.
- One sub-module: fetch_fifo — 2-entry synchronous FIFO with push, pop, flush, count, registered head.
- rom_fetch holds pc, inflight tracking, issue logic and the ROM address mux.

Test Plan:
- Bench setup: rom model preloaded mem[k]=16'hA500|k; INSTR_READY=1.
- Reset release + streaming:
  - 2 cycles after RST drops, INSTR_VALID=1, INSTR_OUT=16'hA500, INSTR_PC=0.
  - Then 16'hA501, 16'hA502... every cycle with no gaps.
- Backpressure: drop INSTR_READY for 5 cycles after PC=3 is presented.
  - Head holds 16'hA503/PC=3; count reaches 2; ROM_ADDRESS frozen at 5.
  - On release, the sequence resumes 3,4,5,6 with no loss or duplicate.
- Branch: BRANCH_VALID with target=8'h40 while FIFO is full.
  - Next cycle INSTR_VALID=0.
  - Cycle n+2: INSTR_OUT=16'hA540, PC=8'h40, then 8'h41.
  - Stale words 8'h05/8'h06 never appear.
- Back-to-back branches to 8'h10 then 8'h20: only 8'h20 and successors are delivered.
- Wrap: branch to 8'hFE. Delivered PCs are FE, FF, 00, 01 with data A5FE, A5FF, A500, A501.
- Async reset mid-stream (RST pulsed between edges):
  - INSTR_VALID=0 immediately; ROM_ADDRESS=RESET_VECTOR.
  - After release, restart from PC 0 as in the first scenario.
  - Random READY toggling for 1000 cycles: scoreboard PC sequence is strictly +1 mod 256 except at branches.
